imem_program_loader: RTL and testbench

Byte-stream program loader for the 4-stage pipelined processor. It accepts a framed stream of 8-bit instruction bytes over a valid/ready handshake and writes them into instruction memory from address 0. While loading, it holds the processor in reset. It releases the processor only after the frame's checksum verifies. It is the writer at the far end of the instruction-memory interface that the processor's fetch stage reads.

---
 rtl/imem_program_loader.sv | 168 ++++++++++++++++
 tb/tb_imem_program_loader.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_program_loader
// Brief    : Framed byte-stream loader that writes instruction memory from
//            address 0 and holds the processor in reset until the checksum passes.
// Revision : 1.0  initial release
// ============================================================================
module imem_program_loader #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       cpu_run,
    output logic       load_done,
    output logic       load_error,
    output logic       busy
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_GET_LEN  = 2'd1;
    localparam logic [1:0] S_GET_DATA = 2'd2;
    localparam logic [1:0] S_GET_CHK  = 2'd3;

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;

    logic       r_ready;
    logic       r_we;
    logic [7:0] r_mem_addr;
    logic [7:0] r_mem_wdata;
    logic       r_run;
    logic       r_done;
    logic       r_err;
    logic       r_busy;
    logic [8:0] r_cnt;
    logic [7:0] r_acc;
    logic [7:0] r_addr;

    logic       w_we;
    logic [7:0] w_mem_addr;
    logic [7:0] w_mem_wdata;
    logic       w_run;
    logic       w_done;
    logic       w_err;
    logic       w_busy;
    logic [8:0] w_cnt;
    logic [7:0] w_acc;
    logic [7:0] w_addr;

    logic       w_accept;
    logic       w_is_sync;
    logic [7:0] w_chk_sum;
    logic       w_sum_ok;

    assign w_accept  = in_valid & r_ready;
    assign w_is_sync = (in_data == SYNC_BYTE);
    assign w_chk_sum = r_acc + in_data;
    assign w_sum_ok  = (w_chk_sum == 8'd0);

    // State and all outputs live in one register bank so reset clears them together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_ready     <= 1'b0;
            r_we        <= 1'b0;
            r_mem_addr  <= 8'd0;
            r_mem_wdata <= 8'd0;
            r_run       <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_cnt       <= 9'd0;
            r_acc       <= 8'd0;
            r_addr      <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_ready     <= 1'b1;
            r_we        <= w_we;
            r_mem_addr  <= w_mem_addr;
            r_mem_wdata <= w_mem_wdata;
            r_run       <= w_run;
            r_done      <= w_done;
            r_err       <= w_err;
            r_busy      <= w_busy;
            r_cnt       <= w_cnt;
            r_acc       <= w_acc;
            r_addr      <= w_addr;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            case (r_state)
                S_IDLE:     if (w_is_sync) w_state_nxt = S_GET_LEN;
                S_GET_LEN:  w_state_nxt = S_GET_DATA;
                S_GET_DATA: if (r_cnt == 9'd1) w_state_nxt = S_GET_CHK;
                S_GET_CHK:  w_state_nxt = S_IDLE;
                default:    w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_we        = 1'b0;
        w_mem_addr  = r_mem_addr;
        w_mem_wdata = r_mem_wdata;
        w_run       = r_run;
        w_done      = r_done;
        w_err       = r_err;
        w_busy      = r_busy;
        w_cnt       = r_cnt;
        w_acc       = r_acc;
        w_addr      = r_addr;
        if (w_accept) begin
            case (r_state)
                S_IDLE: begin
                    if (w_is_sync) begin
                        w_busy = 1'b1;
                        w_run  = 1'b0;
                        w_done = 1'b0;
                        w_err  = 1'b0;
                        w_acc  = 8'd0;
                    end
                end
                S_GET_LEN: begin
                    // A zero length byte encodes the full 256-byte memory.
                    w_cnt  = (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
                    w_addr = 8'd0;
                    w_acc  = in_data;
                end
                S_GET_DATA: begin
                    w_we        = 1'b1;
                    w_mem_addr  = r_addr;
                    w_mem_wdata = in_data;
                    w_acc       = r_acc + in_data;
                    w_addr      = r_addr + 8'd1;
                    w_cnt       = r_cnt - 9'd1;
                end
                S_GET_CHK: begin
                    w_acc  = w_chk_sum;
                    w_busy = 1'b0;
                    w_done = w_sum_ok;
                    w_err  = ~w_sum_ok;
                    w_run  = w_sum_ok;
                end
                default: ;
            endcase
        end
    end

    assign in_ready   = r_ready;
    assign mem_we     = r_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign cpu_run    = r_run;
    assign load_done  = r_done;
    assign load_error = r_err;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_imem_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_program_loader
// Brief    : Frame-level model and per-cycle compare for imem_program_loader.
// Revision : 1.0  initial release
// ============================================================================
module tb_imem_program_loader;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_run;
    logic       load_done;
    logic       load_error;
    logic       busy;

    imem_program_loader #(.SYNC_BYTE(8'hA5)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_run    (cpu_run),
        .load_done  (load_done),
        .load_error (load_error),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected output state after the most recent rising edge.
    logic       exp_ready = 1'b0;
    logic       exp_we    = 1'b0;
    logic [7:0] exp_addr  = 8'd0;
    logic [7:0] exp_wdata = 8'd0;
    logic       exp_busy  = 1'b0;
    logic       exp_run   = 1'b0;
    logic       exp_done  = 1'b0;
    logic       exp_err   = 1'b0;

    logic [7:0] payload [256];
    logic [7:0] imem    [256];
    int         wr_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("in_ready", in_ready, exp_ready);
        chk("mem_we", mem_we, exp_we);
        if (exp_we) begin
            chk("mem_addr", mem_addr, exp_addr);
            chk("mem_wdata", mem_wdata, exp_wdata);
        end
        chk("busy", busy, exp_busy);
        chk("cpu_run", cpu_run, exp_run);
        chk("load_done", load_done, exp_done);
        chk("load_error", load_error, exp_err);
        if (mem_we === 1'b1) begin
            imem[mem_addr] = mem_wdata;
            wr_cnt++;
        end
    end

    task automatic xfer(input logic [7:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        exp_we   = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            @(posedge clk);
            #1;
            exp_we = 1'b0;
        end
    endtask

    // Sends SYNC, LEN, payload[0..n-1], CHK; expectations follow the frame rules.
    task automatic send_frame(input logic [7:0] len, input logic [7:0] chkb, input int g);
        int          n;
        logic [31:0] sum;
        n = (len == 8'd0) ? 256 : int'(len);
        xfer(8'hA5);
        exp_busy = 1'b1; exp_run = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
        gap(g);
        xfer(len);
        gap(g);
        sum = {24'd0, len};
        for (int i = 0; i < n; i++) begin
            xfer(payload[i]);
            exp_we    = 1'b1;
            exp_addr  = 8'(i);
            exp_wdata = payload[i];
            sum       = sum + {24'd0, payload[i]};
            gap(g);
        end
        xfer(chkb);
        sum      = sum + {24'd0, chkb};
        exp_busy = 1'b0;
        exp_done = (sum % 256) == 0;
        exp_err  = (sum % 256) != 0;
        exp_run  = (sum % 256) == 0;
        gap(g);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        exp_ready = 1'b1;
    endtask

    task automatic good3();
        payload[0] = 8'h11; payload[1] = 8'h22; payload[2] = 8'h33;
    endtask

    initial begin
        int w0;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_busy", busy, 1'b0);
        chk("reset_ready", in_ready, 1'b0);
        release_reset();
        gap(1);

        // Good frame
        good3();
        w0 = wr_cnt;
        send_frame(8'h03, 8'h97, 0);
        chk("good_done", load_done, 1'b1);
        chk("good_run", cpu_run, 1'b1);
        chk("good_writes", wr_cnt - w0, 3);
        chk("good_mem2", imem[2], 8'h33);

        // Bad checksum
        w0 = wr_cnt;
        send_frame(8'h03, 8'h98, 0);
        chk("bad_err", load_error, 1'b1);
        chk("bad_done", load_done, 1'b0);
        chk("bad_run", cpu_run, 1'b0);
        chk("bad_writes", wr_cnt - w0, 3);

        // Junk bytes then a throttled frame with a SYNC value as data
        w0 = wr_cnt;
        xfer(8'h00); gap(2);
        xfer(8'hFF); gap(2);
        payload[0] = 8'hA5; payload[1] = 8'h10;
        send_frame(8'h02, 8'h49, 2);
        chk("junk_writes", wr_cnt - w0, 2);
        chk("junk_mem0", imem[0], 8'hA5);
        chk("junk_mem1", imem[1], 8'h10);
        chk("junk_done", load_done, 1'b1);

        // Max length frame
        for (int i = 0; i < 256; i++) payload[i] = 8'(i);
        w0 = wr_cnt;
        send_frame(8'h00, 8'h80, 0);
        chk("max_writes", wr_cnt - w0, 256);
        chk("max_mem255", imem[255], 8'hFF);
        chk("max_done", load_done, 1'b1);

        // Reset after two of three data bytes
        xfer(8'hA5);
        exp_busy = 1'b1; exp_run = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
        xfer(8'h03);
        xfer(8'h11);
        exp_we = 1'b1; exp_addr = 8'h00; exp_wdata = 8'h11;
        xfer(8'h22);
        exp_we = 1'b1; exp_addr = 8'h01; exp_wdata = 8'h22;
        #1;
        reset = 1'b1;
        #1;
        chk("rst_we", mem_we, 1'b0);
        chk("rst_addr", mem_addr, 8'h00);
        chk("rst_wdata", mem_wdata, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", in_ready, 1'b0);
        exp_ready = 1'b0; exp_we = 1'b0; exp_busy = 1'b0;
        exp_run = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
        release_reset();
        good3();
        send_frame(8'h03, 8'h97, 0);
        chk("rerun_done", load_done, 1'b1);

        // Reload while running
        payload[0] = 8'hC0;
        w0 = wr_cnt;
        send_frame(8'h01, 8'h3F, 0);
        chk("reload_writes", wr_cnt - w0, 1);
        chk("reload_mem0", imem[0], 8'hC0);
        chk("reload_run", cpu_run, 1'b1);

        gap(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
